// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared state encoding and word/block types for the AES stream loader.
package aes_stream_pkg;
    typedef enum logic [2:0] {LOAD_KEY, LOAD_MSG, ARM, RUN, DRAIN} state_e;
    localparam int WORDS_PER_BLOCK = 4;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;
endpackage

// File: rtl/aes_word_shift128.sv
// aes_word_shift128: 128-bit register with clear, parallel load and 32-bit shift-left word load.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i clear; load_i loads block_i;
//        shift_i shifts word_i in at the bottom; q_o current contents.
module aes_word_shift128 import aes_stream_pkg::*; (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  aes_block_t block_i,
    input  aes_word_t  word_i,
    output aes_block_t q_o
);
    aes_block_t q_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) q_q <= '0;
        else if (clr_i) q_q <= '0;
        else if (load_i) q_q <= block_i;
        else if (shift_i) q_q <= {q_q[95:0], word_i};
    assign q_o = q_q;
endmodule

// File: rtl/aes_stream_loader.sv
// aes_stream_loader: word-serial key/ciphertext loader and plaintext streamer around an AES decryption core.
// Ports: CLK, RESET (async active-low); in_data/in_valid/in_ready input word stream; in_newkey
//        first-word key flag; out_data/out_valid/out_ready plaintext stream; AES_KEY, AES_MSG_ENC,
//        AES_START to the core; AES_DONE, AES_MSG_DEC from the core; busy; timeout_err pulse.
// Build option: AES_KEY_CACHE_EN lets a frame with in_newkey=0 reuse the previously loaded key.
module aes_stream_loader import aes_stream_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int WORD_W         = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_newkey,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output aes_block_t        AES_KEY,
    output aes_block_t        AES_MSG_ENC,
    output logic              AES_START,
    input  logic              AES_DONE,
    input  aes_block_t        AES_MSG_DEC,
    output logic              busy,
    output logic              timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          start_q, out_valid_q, timeout_q;
    logic          in_fire, out_fire, skip_key, key_shift, msg_shift, done_cap;
    aes_block_t    buf_q;
    assign in_ready = (state_q == LOAD_KEY) || (state_q == LOAD_MSG);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
`ifdef AES_KEY_CACHE_EN
    logic key_ok_q;
    // A frame whose first word carries in_newkey=0 starts directly with ciphertext, once a key exists.
    assign skip_key = (state_q == LOAD_KEY) && (cnt_q == 2'd0) && key_ok_q && !in_newkey;
`else
    logic unused_newkey;
    assign unused_newkey = in_newkey;
    assign skip_key = 1'b0;
`endif
    assign key_shift = in_fire && (state_q == LOAD_KEY) && !skip_key;
    assign msg_shift = in_fire && ((state_q == LOAD_MSG) || skip_key);
    assign done_cap  = (state_q == RUN) && AES_DONE;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= LOAD_KEY;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            key_ok_q    <= 1'b0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                LOAD_KEY: if (in_fire) begin
                    if (skip_key) begin
                        state_q <= LOAD_MSG;
                        cnt_q   <= 2'd1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= LOAD_MSG;
`ifdef AES_KEY_CACHE_EN
                            key_ok_q <= 1'b1;
`endif
                        end
                    end
                end
                LOAD_MSG: if (in_fire) begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= ARM;
                end
                // Hold off until any stale done from the previous block has cleared.
                ARM: if (!AES_DONE) begin
                    state_q  <= RUN;
                    start_q  <= 1'b1;
                    to_cnt_q <= '0;
                end
                RUN: if (AES_DONE) begin
                    state_q     <= DRAIN;
                    start_q     <= 1'b0;
                    out_valid_q <= 1'b1;
                end else begin
                    to_cnt_q <= (to_cnt_q == TW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + 1'b1;
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        start_q   <= 1'b0;
                        state_q   <= LOAD_KEY;
                    end
                end
                DRAIN: if (out_fire) begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        out_valid_q <= 1'b0;
                        state_q     <= LOAD_KEY;
                    end
                end
                default: state_q <= LOAD_KEY;
            endcase
        end
    end
    aes_word_shift128 u_key (
        .clk_i(CLK), .rst_ni(RESET), .clr_i(1'b0), .load_i(1'b0), .shift_i(key_shift),
        .block_i('0), .word_i(in_data), .q_o(AES_KEY)
    );
    aes_word_shift128 u_msg (
        .clk_i(CLK), .rst_ni(RESET), .clr_i(1'b0), .load_i(1'b0), .shift_i(msg_shift),
        .block_i('0), .word_i(in_data), .q_o(AES_MSG_ENC)
    );
    aes_word_shift128 u_buf (
        .clk_i(CLK), .rst_ni(RESET), .clr_i(1'b0), .load_i(done_cap), .shift_i(out_fire),
        .block_i(AES_MSG_DEC), .word_i('0), .q_o(buf_q)
    );
    assign out_data    = buf_q[127:96];
    assign out_valid   = out_valid_q;
    assign AES_START   = start_q;
    assign timeout_err = timeout_q;
    assign busy        = !((state_q == LOAD_KEY) && (cnt_q == 2'd0));
endmodule
